// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the digit-serial BCD adder
//
// Purpose: FSM state encoding and BCD constants used by the controller and
//          the one-digit adder.
// Contents:
//   state_t   - IDLE / ADD / DONE controller states
//   BCD_MAX   - largest valid BCD digit value
//   BCD_CORR  - correction added when a digit sum exceeds BCD_MAX
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// rtl/bcd_serial_adder_ctrl_if.sv - request/result bundle of the serial BCD adder
//
// Purpose: groups operands, handshake and result signals of the controller.
// Signals:
//   start, a, b, cin          - request side (driven by the master)
//   ready, busy, done         - handshake status (driven by the slave)
//   sum, cout, err            - result, held until the next accepted start
// Modports: master (requester), slave (the adder controller).
interface bcd_serial_adder_ctrl_if #(
  parameter int NDIG = 4
);

  logic                start;
  logic [4*NDIG-1:0]   a;
  logic [4*NDIG-1:0]   b;
  logic                cin;
  logic                ready;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   sum;
  logic                cout;
  logic                err;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - combinational one-digit BCD adder with validity flag
//
// Purpose: adds two BCD digits and a decimal carry, applying the +6
//          correction when the binary sum exceeds 9.
// Ports:
//   i_a, i_b   - input digits (values above 9 are still processed)
//   i_cin      - decimal carry in
//   o_s        - corrected result digit
//   o_cout     - decimal carry out
//   o_invalid  - either input digit is above 9
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout,
  output logic       o_invalid
);

  logic [4:0] w_t;

  assign w_t = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_cin};

  // Correction is applied mod 16, so invalid digits give a deterministic
  // (if decimally meaningless) result.
  always_comb begin
    o_s    = w_t[3:0];
    o_cout = 1'b0;
    if (w_t > {1'b0, BCD_MAX}) begin
      o_s    = w_t[3:0] + BCD_CORR;
      o_cout = 1'b1;
    end
  end

  assign o_invalid = (i_a > BCD_MAX) || (i_b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - digit-serial NDIG-digit BCD adder controller
//
// Purpose: latches two packed BCD operands on start and adds them one digit
//          per clock (LSD first) through a single shared digit adder.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - slave side of bcd_serial_adder_ctrl_if (start/a/b/cin in,
//            ready/busy/done/sum/cout/err out)
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_serial_adder_ctrl_if.slave bus
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t              r_state;
  logic [4*NDIG-1:0]   r_a;
  logic [4*NDIG-1:0]   r_b;
  logic [4*NDIG-1:0]   r_sum;
  logic [IDXW-1:0]     r_idx;
  logic                r_carry;
  logic                r_cout;
  logic                r_err;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;

  logic [3:0]          w_a_d;
  logic [3:0]          w_b_d;
  logic [3:0]          w_s;
  logic                w_c;
  logic                w_inv;

  // Select the current digit pair from the latched operands.
  always_comb begin
    w_a_d = '0;
    w_b_d = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (r_idx == IDXW'(d)) begin
        w_a_d = r_a[4*d +: 4];
        w_b_d = r_b[4*d +: 4];
      end
    end
  end

  bcd_digit_adder u_digit (
    .i_a       (w_a_d),
    .i_b       (w_b_d),
    .i_cin     (r_carry),
    .o_s       (w_s),
    .o_cout    (w_c),
    .o_invalid (w_inv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ADD;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ADD: begin
          for (int d = 0; d < NDIG; d++) begin
            if (r_idx == IDXW'(d)) r_sum[4*d +: 4] <= w_s;
          end
          r_carry <= w_c;
          r_err   <= r_err | w_inv;
          if (r_idx == IDXW'(NDIG - 1)) begin
            r_cout  <= w_c;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - self-checking bench for bcd_serial_adder_ctrl
module tb_bcd_serial_adder_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bcd_serial_adder_ctrl_if #(.NDIG(NDIG)) bus ();

  bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: digit-by-digit decimal addition with the +6 correction rule.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c_in,
                       output logic [W-1:0] s, output logic c_out, output logic e);
    int c;
    int ad;
    int bd;
    int t;
    int sd;
    c = int'(c_in);
    s = '0;
    e = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      ad = int'((a >> (4 * d)) & W'(15));
      bd = int'((b >> (4 * d)) & W'(15));
      t  = ad + bd + c;
      if (t > 9) begin
        sd = (t + 6) % 16;
        c  = 1;
      end else begin
        sd = t;
        c  = 0;
      end
      if (ad > 9 || bd > 9) e = 1'b1;
      s = s | (W'(sd) << (4 * d));
    end
    c_out = (c != 0);
  endtask

  // mode: 0 plain, 1 scramble a/b/cin during ADD, 2 assert start during ADD
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c_in,
                        input int mode, input int hold);
    logic [W-1:0] es;
    logic         ec;
    logic         ee;
    int           cyc;
    int           bcnt;
    model(a, b, c_in, es, ec, ee);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c_in;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("accept_ready", 32'(bus.ready), 32'd0);
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < 3 * NDIG + 4) begin
      if (bus.busy) bcnt++;
      if (mode == 1) begin
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
      end
      if (mode == 2) begin
        bus.a     = W'(16'h1111);
        bus.b     = W'(16'h1111);
        bus.start = 1'b1;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(cyc), 32'(NDIG));
    check("busy_cycles", 32'(bcnt), 32'(NDIG));
    check("done_excl", 32'({bus.ready, bus.busy}), 32'd0);
    check("sum", 32'(bus.sum), 32'(es));
    check("cout", 32'(bus.cout), 32'(ec));
    check("err", 32'(bus.err), 32'(ee));
    tick();
    check("done_pulse", 32'({bus.done, bus.ready, bus.busy}), 32'b010);
    for (int i = 0; i < hold; i++) begin
      check("hold", 32'({bus.err, bus.cout, bus.sum}), 32'({ee, ec, es}));
      tick();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    tick();
    tick();
    check("rst_flags", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("rst_res", 32'({bus.err, bus.cout, bus.sum}), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(W'(16'h1234), W'(16'h5678), 1'b0, 0, 1);
    run_op(W'(16'h9999), W'(16'h0001), 1'b0, 0, 1);
    run_op(W'(16'h0000), W'(16'h0000), 1'b1, 0, 1);
    run_op(W'(16'h00A5), W'(16'h0003), 1'b0, 0, 1);
    run_op(W'(16'h2468), W'(16'h1357), 1'b0, 2, 1);
    run_op(W'(16'h0042), W'(16'h0017), 1'b0, 0, 0);

    // Reset during the second ADD cycle aborts without a done pulse.
    bus.a     = W'(16'h4321);
    bus.b     = W'(16'h8765);
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_flags", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("abort_res", 32'({bus.err, bus.cout, bus.sum}), 32'd0);
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op(W'(16'h0500), W'(16'h0500), 1'b0, 0, 1);
    run_op(W'(16'h3917), W'(16'h5086), 1'b1, 1, 10);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = '0;
      rb = '0;
      for (int d = 0; d < NDIG; d++) begin
        ra = ra | (W'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9)) << (4 * d));
        rb = rb | (W'($urandom_range(0, 9)) << (4 * d));
      end
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
